// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encodings and index-width helper.
package uart_tx_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SEND = 2'd1;
    localparam state_t S_WAIT = 2'd2;

    // Width of an index into n requesters; never zero so ports stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    // Scan last+1, last+2, ... modulo NREQ; the first hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte producers with round-robin fairness.
// Runs the send/busy handshake and returns a one-cycle ack or timeout nak.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned IW     = idx_width(NREQ),
    localparam int unsigned CW     = $clog2(TIMEOUT)
) (
    input  logic              ref_clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] data_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   nak_o,
    output logic              tx_send_o,
    output logic [7:0]        tx_in_o,
    input  logic              tx_busy_i,
    output logic [IW-1:0]     grant_id_o,
    output logic              active_o,
    output logic              err_o
);

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [7:0]      tx_in_q, tx_in_d;
    logic            tx_send_q, tx_send_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] nak_q, nak_d;
    logic            err_q, err_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [7:0]      data_bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign data_bytes[g] = data_i[8*g +: 8];
    end

    // The last grant doubles as the round-robin pointer.
    uart_tx_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (grant_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state logic for the handshake FSM, timeout counter and ack/nak pulses.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_in_d   = tx_in_q;
        tx_send_d = tx_send_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        nak_d     = '0;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                // A busy transmitter may be finishing a frame from before our reset.
                if (pick_valid && !tx_busy_i) begin
                    grant_d   = pick_idx;
                    tx_in_d   = data_bytes[pick_idx];
                    tx_send_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_busy_i) begin
                    tx_send_d = 1'b0;
                    state_d   = S_WAIT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tx_send_d      = 1'b0;
                    nak_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Frame length depends on the bit clock, so no timeout here.
                if (!tx_busy_i) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops tx_send immediately and abandons any in-flight byte.
    always_ff @(posedge ref_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            grant_q   <= IW'(NREQ - 1);
            tx_in_q   <= '0;
            tx_send_q <= 1'b0;
            cnt_q     <= '0;
            ack_q     <= '0;
            nak_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_in_q   <= tx_in_d;
            tx_send_q <= tx_send_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            nak_q     <= nak_d;
            err_q     <= err_d;
        end
    end

    assign ack_o      = ack_q;
    assign nak_o      = nak_q;
    assign tx_send_o  = tx_send_q;
    assign tx_in_o    = tx_in_q;
    assign grant_id_o = grant_q;
    assign active_o   = (state_q != S_IDLE);
    assign err_o      = err_q;

endmodule
